// File: rtl/zuma_config_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zuma_config_loader: packs host bytes into 32-bit words for ZUMA config.  |
// | Optional checksum trailer: ZUMA_CFG_CHECKSUM_EN.      Revision: 1.0      |
// +--------------------------------------------------------------------------+
module zuma_config_loader #(
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       config_data,
  output logic              config_en,
  output logic [ADDR_W-1:0] config_addr,
  output logic              busy,
  output logic              done,
  output logic              cfg_error
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic [31:0]       word_q;
  logic [IDX_W-1:0]  idx_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              config_en_q;
  logic [31:0]       config_data_q;
  logic [ADDR_W-1:0] config_addr_q;

  logic              byte_acc;
  logic [31:0]       word_d;
  logic [31:0]       rev_d;

`ifdef ZUMA_CFG_CHECKSUM_EN
  logic [31:0]       sum_q;
  logic [31:0]       sum_d;
  logic              cfg_error_q;
`endif

  // word_d is the packing register with the current byte already merged in
  always_comb begin
    byte_acc = in_valid & in_ready_q;
    word_d   = word_q;
    word_d[{cnt_q, 3'b000} +: 8] = in_data;
    rev_d    = '0;
    for (int i = 0; i < 32; i++) begin
      rev_d[31-i] = word_d[i];
    end
`ifdef ZUMA_CFG_CHECKSUM_EN
    sum_d = sum_q + word_d;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      word_q        <= '0;
      idx_q         <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      config_en_q   <= 1'b0;
      config_data_q <= '0;
      config_addr_q <= '0;
`ifdef ZUMA_CFG_CHECKSUM_EN
      sum_q         <= '0;
      cfg_error_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef ZUMA_CFG_CHECKSUM_EN
            sum_q       <= '0;
            cfg_error_q <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (byte_acc) begin
            word_q <= word_d;
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q       <= S_WRITE;
              in_ready_q    <= 1'b0;
              config_en_q   <= 1'b1;
              config_data_q <= rev_d;
              config_addr_q <= ADDR_W'(idx_q);
`ifdef ZUMA_CFG_CHECKSUM_EN
              sum_q         <= sum_d;
`endif
            end
          end
        end
        S_WRITE: begin
          config_en_q <= 1'b0;
          if (idx_q == LAST_IDX) begin
`ifdef ZUMA_CFG_CHECKSUM_EN
            state_q    <= S_CHECK;
            in_ready_q <= 1'b1;
`else
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            idx_q      <= idx_q + 1'b1;
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
          end
        end
`ifdef ZUMA_CFG_CHECKSUM_EN
        // Trailer word is compared against the running sum, never written out
        S_CHECK: begin
          if (byte_acc) begin
            word_q <= word_d;
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              cfg_error_q <= (sum_q != word_d);
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign config_en   = config_en_q;
  assign config_data = config_data_q;
  assign config_addr = config_addr_q;
`ifdef ZUMA_CFG_CHECKSUM_EN
  assign cfg_error   = cfg_error_q;
`else
  assign cfg_error   = 1'b0;
`endif

endmodule
`default_nettype wire
